// File: rtl/layer_seq_pkg.sv
// ----------------------------------------------------------------------------
// layer_seq_pkg : shared state encoding, datapath widths and saturation code
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package layer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_QUANT = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

  localparam int ACC_W  = 23;
  localparam int PROD_W = 16;
  localparam int BIAS_W = 16;

  localparam logic [7:0] SAT_CODE = 8'd127;

  function automatic logic [ACC_W-1:0] sext16(input logic [15:0] v);
    return {{(ACC_W-16){v[15]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_requant.sv
// ----------------------------------------------------------------------------
// acc_requant : 23-bit accumulator to unsigned 8-bit ReLU code (0..127)
// Rounding enabled by LAYER_SEQ_ROUND_EN; truncation otherwise.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acc_requant
  import layer_seq_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  output logic [7:0]       code
);

`ifdef LAYER_SEQ_ROUND_EN
  always_comb begin
    // Exact half (acc[5] set, lower bits clear) rounds down.
    code = acc[13:6] + {7'd0, acc[5] & (|acc[4:0])};
    if (code[7]) begin
      code = SAT_CODE;
    end
    if (acc[ACC_W-1]) begin
      code = 8'd0;
    end else if (|acc[21:13]) begin
      code = SAT_CODE;
    end
  end
`else
  logic unused_lsbs;
  assign unused_lsbs = ^acc[5:0];

  always_comb begin
    code = acc[13:6];
    if (acc[ACC_W-1]) begin
      code = 8'd0;
    end else if (|acc[21:13]) begin
      code = SAT_CODE;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/layer_mac_sequencer.sv
// ----------------------------------------------------------------------------
// layer_mac_sequencer : schedules all neurons of a layer over one shared 8x8 MAC
// Rounding selected by LAYER_SEQ_ROUND_EN (inside acc_requant).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module layer_mac_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_INPUTS  = 15,
  parameter int NUM_NEURONS = 16,
  localparam int JW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int WW = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [JW-1:0]     act_addr,
  output logic [WW-1:0]     w_addr,
  output logic [NW-1:0]     bias_addr,
  input  logic signed [7:0] act_rdata,
  input  logic signed [7:0] w_rdata,
  input  logic signed [15:0] bias_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NW-1:0]     out_idx,
  output logic [7:0]        out_data
);

  localparam logic [JW-1:0] LAST_J = JW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);

  state_e            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [JW-1:0]     j_q, j_d;
  logic [WW-1:0]     w_base_q, w_base_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [NW-1:0]     out_idx_q, out_idx_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              done_q, done_d;

  logic signed [PROD_W-1:0] prod;
  logic [7:0]               quant_code;

  // Memory data arrives one cycle after its address, so the product
  // consumed in MAC cycle j belongs to index j-1.
  assign prod = act_rdata * w_rdata;

  acc_requant u_requant (
    .acc  (acc_q),
    .code (quant_code)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    j_d         = j_q;
    w_base_d    = w_base_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the finished run.
        if (start && !done_q) begin
          state_d  = ST_LOAD;
          n_d      = '0;
          w_base_d = '0;
        end
      end
      ST_LOAD: begin
        j_d     = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        if (j_q == '0) begin
          acc_d = sext16(bias_rdata);
        end else begin
          acc_d = acc_q + sext16(prod);
        end
        if (j_q == LAST_J) begin
          state_d = ST_DRAIN;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      ST_DRAIN: begin
        acc_d   = acc_q + sext16(prod);
        state_d = ST_QUANT;
      end
      ST_QUANT: begin
        out_data_d  = quant_code;
        out_idx_d   = n_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (n_q == LAST_N) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            n_d      = n_q + NW'(1);
            w_base_d = w_base_q + WW'(NUM_INPUTS);
            state_d  = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      j_q         <= '0;
      w_base_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      j_q         <= j_d;
      w_base_q    <= w_base_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

  assign act_addr  = (state_q == ST_MAC)  ? j_q : '0;
  assign w_addr    = (state_q == ST_MAC)  ? (w_base_q + WW'(j_q)) : '0;
  assign bias_addr = (state_q == ST_LOAD) ? n_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_layer_mac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_layer_mac_sequencer : scoreboard bench, NUM_INPUTS=3, NUM_NEURONS=2
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_layer_mac_sequencer;

  localparam int NI = 3;
  localparam int NN = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, out_valid;
  logic [1:0]  act_addr;
  logic [2:0]  w_addr;
  logic [0:0]  bias_addr;
  logic [0:0]  out_idx;
  logic [7:0]  out_data;
  logic signed [7:0]  act_rdata = '0;
  logic signed [7:0]  w_rdata = '0;
  logic signed [15:0] bias_rdata = '0;

  logic signed [7:0]  act_mem  [0:3];
  logic signed [7:0]  w_mem    [0:7];
  logic signed [15:0] bias_mem [0:1];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [8:0] exp_q [$];
  logic prev_final = 1'b0;

  always #5 clk = ~clk;

  layer_mac_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .act_addr   (act_addr),
    .w_addr     (w_addr),
    .bias_addr  (bias_addr),
    .act_rdata  (act_rdata),
    .w_rdata    (w_rdata),
    .bias_rdata (bias_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data)
  );

  always @(posedge clk) begin
    act_rdata  <= act_mem[act_addr];
    w_rdata    <= w_mem[w_addr];
    bias_rdata <= bias_mem[bias_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected {idx,data} per handshake.
  always @(negedge clk) begin : mon
    logic       hs_final;
    logic [8:0] e;
    hs_final = 1'b0;
    if (done) begin
      done_cnt++;
      chk("done_follows_last_handshake", int'(prev_final), 1);
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("output_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_idx", int'(out_idx), int'(e[8]));
        chk("out_data", int'(out_data), int'(e[7:0]));
      end
      hs_final = (int'(out_idx) == NN - 1);
    end
    prev_final = hs_final;
  end

  task automatic load_uniform(input int a, input int w, input int b0, input int b1);
    for (int i = 0; i < 4; i++) act_mem[i] = 8'(a);
    for (int i = 0; i < 8; i++) w_mem[i] = 8'(w);
    bias_mem[0] = 16'(b0);
    bias_mem[1] = 16'(b1);
  endtask

  task automatic check_reset_values();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_addrs", int'({act_addr, w_addr, bias_addr}), 0);
  endtask

  // mode: 0 plain, 1 latency/period, 2 backpressure stall, 3 start during done
  task automatic run_layer(input logic [7:0] e0, input logic [7:0] e1, input int mode);
    int t;
    int d0;
    exp_q.push_back({1'b0, e0});
    exp_q.push_back({1'b1, e1});
    d0 = done_cnt;
    out_ready = (mode != 2);
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    if (mode == 1) begin
      chk("busy_in_load", int'(busy), 1);
      t = 0;
      while (!out_valid && t < 100) begin @(posedge clk) #1; t++; end
      chk("first_valid_latency", t, NI + 3);
      t = 0;
      do begin @(posedge clk) #1; t++; end while (!out_valid && t < 100);
      chk("neuron_period", t, NI + 4);
    end
    if (mode == 2) begin
      t = 0;
      while (!out_valid && t < 100) begin @(posedge clk) #1; t++; end
      chk("stall_valid_seen", int'(out_valid), 1);
      for (int k = 0; k < 5; k++) begin
        start = (k == 2);
        @(posedge clk) #1;
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(e0));
        chk("stall_idx", int'(out_idx), 0);
        chk("stall_addrs", int'({act_addr, w_addr, bias_addr}), 0);
      end
      start = 1'b0;
      out_ready = 1'b1;
    end
    t = 0;
    while (!done && t < 300) begin @(posedge clk) #1; t++; end
    chk("done_seen", int'(done), 1);
    chk("busy_low_at_done", int'(busy), 0);
    if (mode == 3) start = 1'b1;
    #5;
    chk("done_count", done_cnt - d0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk) #1;
    start = 1'b0;
    chk("done_single_pulse", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    if (mode == 2) begin
      repeat (3) @(posedge clk);
      #1;
      chk("stall_start_ignored", int'(busy), 0);
    end
  endtask

  task automatic reset_mid_mac();
    int t;
    int d0;
    exp_q.push_back({1'b0, 8'd2});
    exp_q.push_back({1'b1, 8'd8});
    d0 = done_cnt;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    t = 0;
    while (!(busy && bias_addr == 1'b1) && t < 100) begin @(posedge clk) #1; t++; end
    chk("reached_neuron1_load", int'(bias_addr), 1);
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("mac_act_addr", int'(act_addr), 1);
    chk("mac_w_addr", int'(w_addr), NI + 1);
    reset = 1'b1;
    @(posedge clk) #1;
    check_reset_values();
    reset = 1'b0;
    exp_q.delete();
    repeat (NI + 6) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("no_valid_after_reset", int'(out_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) act_mem[i] = '0;
    for (int i = 0; i < 8; i++) w_mem[i] = '0;
    bias_mem[0] = '0;
    bias_mem[1] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    @(posedge clk) #1;

    // acc = 3*64 + 512 = 704 -> 11
    load_uniform(64, 1, 512, 512);
    run_layer(8'd11, 8'd11, 1);

    // acc = -30 -> 0; start coinciding with done must be ignored
    load_uniform(10, -1, 0, 0);
    run_layer(8'd0, 8'd0, 3);

    // acc = 48387 -> saturate
    load_uniform(127, 127, 0, 0);
    run_layer(8'd127, 8'd127, 0);

    // bias 97: 1 rem 33 rounds up; bias 96: exact half rounds down
    load_uniform(5, 0, 97, 96);
`ifdef LAYER_SEQ_ROUND_EN
    run_layer(8'd2, 8'd1, 0);
`else
    run_layer(8'd1, 8'd1, 0);
`endif

    // 8160 -> 127 exact; 8191 rounds to 128 and clamps to 127
    load_uniform(5, 0, 8160, 8191);
    run_layer(8'd127, 8'd127, 0);

    // distinct weights per neuron: 140 -> 2, 520 -> 8
    act_mem[0] = 8'sd10; act_mem[1] = 8'sd20; act_mem[2] = 8'sd30;
    w_mem[0] = 8'sd1;  w_mem[1] = 8'sd2; w_mem[2] = 8'sd3;
    w_mem[3] = -8'sd1; w_mem[4] = 8'sd4; w_mem[5] = 8'sd5;
    bias_mem[0] = 16'sd0;
    bias_mem[1] = 16'sd300;
    run_layer(8'd2, 8'd8, 2);

    reset_mid_mac();
    run_layer(8'd2, 8'd8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
